// File: rtl/pio_master_pkg.sv
// pio_master_pkg: shared types and constants for the PIO Avalon-MM initiator.
// Contents: FSM state enum, wait-counter width (covers READ_LATENCY 0..3),
// command op encoding (cmd_write value for a read and for a write).
package pio_master_pkg;
    typedef enum logic [2:0] {IDLE, WR, RD, RB, WAIT, RSP} state_t;
    localparam int LAT_W = 2;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/pio_master_rsp_slot.sv
// pio_master_rsp_slot: single-entry valid/ready response register.
// Ports: i_clk, i_reset (async, active-high); i_load captures i_data/i_error
// and raises o_valid; o_valid drops when i_ready is seen; o_data/o_error are
// held stable while o_valid is high.
module pio_master_rsp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_error,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_error
);
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_error <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_error <= i_error;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pio_avalon_master.sv
// pio_avalon_master: command/response to Avalon-MM PIO initiator.
// Build option: PIO_MASTER_READBACK_EN adds a readback read after every
// write, returning the read value and a masked mismatch flag.
// Ports:
//   i_clk, i_reset (async, active-high)
//   command:  i_cmd_valid / o_cmd_ready, i_cmd_write, i_cmd_address, i_cmd_writedata
//   response: o_rsp_valid / i_rsp_ready, o_rsp_readdata, o_rsp_error
//   status:   o_busy (state other than IDLE)
//   Avalon:   o_address, o_chipselect, o_write_n, o_writedata, i_readdata
module pio_avalon_master
    import pio_master_pkg::*;
#(
    parameter int                 ADDR_W       = 2,
    parameter int                 DATA_W       = 32,
    parameter int                 READ_LATENCY = 0,
    parameter logic [DATA_W-1:0]  VERIFY_MASK  = '1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_address,
    input  logic [DATA_W-1:0] i_cmd_writedata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_readdata,
    output logic              o_rsp_error,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_chipselect,
    output logic              o_write_n,
    output logic [DATA_W-1:0] o_writedata,
    input  logic [DATA_W-1:0] i_readdata
);
    if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
        $error("READ_LATENCY must be 0..3");
    end
    if (VERIFY_MASK == '0) begin : g_bad_mask
        $error("VERIFY_MASK must select at least one bit");
    end

    state_t             r_state;
    logic               r_cmd_ready;
    logic               r_cs;
    logic               r_wn;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [LAT_W-1:0]   r_cnt;
    logic               w_sample;
    logic               w_load;
    logic               w_error;
    logic [DATA_W-1:0]  w_rsp_data;

    // readdata is valid at the end of the strobe cycle (latency 0) or at the end of the last WAIT cycle
    assign w_sample   = ((r_state == RD || r_state == RB) && READ_LATENCY == 0) ||
                        (r_state == WAIT && r_cnt == '0);
    assign w_rsp_data = w_sample ? i_readdata : '0;

`ifdef PIO_MASTER_READBACK_EN
    logic r_op;
    assign w_load  = w_sample;
    // only a readback (op = write) is compared; plain reads never flag
    assign w_error = w_sample && r_op == OP_WR && |((i_readdata ^ r_wdata) & VERIFY_MASK);
`else
    assign w_load  = w_sample || r_state == WR;
    assign w_error = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_cs        <= 1'b0;
            r_wn        <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
`ifdef PIO_MASTER_READBACK_EN
            r_op        <= OP_RD;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= i_cmd_address;
                        r_wdata     <= i_cmd_writedata;
                        r_cs        <= 1'b1;
                        r_wn        <= (i_cmd_write == OP_RD);
                        r_state     <= (i_cmd_write == OP_WR) ? WR : RD;
`ifdef PIO_MASTER_READBACK_EN
                        r_op        <= i_cmd_write;
`endif
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR: begin
`ifdef PIO_MASTER_READBACK_EN
                    // write strobe is followed directly by the readback read strobe
                    r_cs    <= 1'b1;
                    r_wn    <= 1'b1;
                    r_state <= RB;
`else
                    r_cs    <= 1'b0;
                    r_wn    <= 1'b1;
                    r_state <= RSP;
`endif
                end
                RD, RB: begin
                    r_cs    <= 1'b0;
                    r_wn    <= 1'b1;
                    r_cnt   <= LAT_W'(READ_LATENCY - 1);
                    r_state <= (READ_LATENCY == 0) ? RSP : WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= RSP;
                    else r_cnt <= r_cnt - LAT_W'(1);
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pio_master_rsp_slot #(.DATA_W(DATA_W)) u_rsp_slot (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_data  (w_rsp_data),
        .i_error (w_error),
        .i_ready (i_rsp_ready),
        .o_valid (o_rsp_valid),
        .o_data  (o_rsp_readdata),
        .o_error (o_rsp_error)
    );

    assign o_cmd_ready  = r_cmd_ready;
    assign o_busy       = r_state != IDLE;
    assign o_address    = r_addr;
    assign o_chipselect = r_cs;
    assign o_write_n    = r_wn;
    assign o_writedata  = r_wdata;
endmodule
